// File: rtl/pll_mon_pkg.sv
// Shared state encodings and sizing helper for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    PLL_MON_RESET_PLL = 2'd0,
    PLL_MON_WAIT_LOCK = 2'd1,
    PLL_MON_STABILIZE = 2'd2,
    PLL_MON_RUN       = 2'd3
  } pll_mon_state_t;

  localparam logic [1:0] ST_RESET_PLL = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABILIZE = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Bits needed to count 0 .. max_val-1, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/pll_mon_sync.sv
// Two-flop synchroniser, reset to 0; the single home for CDC timing constraints.
module pll_mon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock supervisor and system reset sequencer for the ECP5 EHXPLLL.
// Define PLL_MON_LOSS_CNT_EN to implement the saturating loss-of-lock counter.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 256,
  parameter int RST_PULSE     = 16,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_locked,
  output logic             out_pll_rst,
  output logic             out_sys_rst_n,
  output logic             out_timeout,
  output logic [1:0]       out_state,
  output logic [CNT_W-1:0] out_loss_cnt
);

  localparam int CNT_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > RST_PULSE) ? CNT_MAX_A : RST_PULSE;
  localparam int CW        = cnt_width(CNT_MAX);
  localparam int GW        = cnt_width(GLITCH_CYCLES);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);

  logic          lock_s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          timeout_q, timeout_d;
`ifdef PLL_MON_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

  pll_mon_sync u_lock_sync (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .d     (in_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    gcnt_d    = '0;
    timeout_d = timeout_q;
`ifdef PLL_MON_LOSS_CNT_EN
    loss_cnt_d = loss_cnt_q;
`endif
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins.
        if (lock_s) begin
          state_d = ST_STABILIZE;
        end else if (cnt_q == LOCK_LAST) begin
          state_d   = ST_RESET_PLL;
          timeout_d = 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      default: begin
        // RUN: the shared counter idles at zero; only the glitch filter counts.
        cnt_d = '0;
        if (!lock_s) begin
          if (gcnt_q == GLITCH_LAST) begin
            state_d = ST_RESET_PLL;
`ifdef PLL_MON_LOSS_CNT_EN
            if (loss_cnt_q != {CNT_W{1'b1}}) loss_cnt_d = loss_cnt_q + 1'b1;
`endif
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    pll_rst_d   = (state_d == ST_RESET_PLL);
    sys_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef PLL_MON_LOSS_CNT_EN
      loss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      timeout_q   <= timeout_d;
`ifdef PLL_MON_LOSS_CNT_EN
      loss_cnt_q  <= loss_cnt_d;
`endif
    end
  end

  assign out_pll_rst   = pll_rst_q;
  assign out_sys_rst_n = sys_rst_n_q;
  assign out_timeout   = timeout_q;
  assign out_state     = state_q;
`ifdef PLL_MON_LOSS_CNT_EN
  assign out_loss_cnt  = loss_cnt_q;
`else
  assign out_loss_cnt  = '0;
`endif

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Lock supervisor and reset sequencer for the ECP5 EHXPLLL clock generator on the Karnix board.
- Runs on the 25 MHz reference clock and samples the PLL's asynchronous `locked` output.
- Drives the PLL `RST` input and retries if the PLL fails to lock within a timeout.
- Releases the system reset only after lock has been stable for a programmed time; re-asserts it on a filtered loss of lock.
- Sits between the PLL instance and the Murax SoC reset tree.

## Interface
Parameters:
- `LOCK_TIMEOUT`, default 25000: cycles to wait for lock after the PLL reset pulse (1 ms at 25 MHz). Must be ≥ 2.
- `STABLE_CYCLES`, default 256: consecutive high lock samples required before the system reset is released. Must be ≥ 2.
- `RST_PULSE`, default 16: width of the PLL reset pulse, in cycles. Must be ≥ 2.
- `GLITCH_CYCLES`, default 4: consecutive low lock samples in RUN that count as a loss of lock. Must be ≥ 1.
- `CNT_W`, default 8: width of the loss-event counter.

Ports:
- `in_clk` in 1: 25 MHz reference clock (same net as the PLL `CLKI`).
- `in_rst_n` in 1: asynchronous, active-low reset (power-on or button).
- `in_locked` in 1: PLL `LOCK` output; asynchronous to `in_clk`.
- `out_pll_rst` out 1: connects to EHXPLLL `RST`; active high.
- `out_sys_rst_n` out 1: active-low system reset. Assertion is immediate on `in_rst_n`; release is synchronous to `in_clk`. The consumer re-synchronises it into the 75 MHz domain.
- `out_timeout` out 1: sticky flag, set by any lock timeout.
- `out_state` out 2: current FSM state encoding.
- `out_loss_cnt` out CNT_W: saturating count of loss-of-lock events.

## Operation
- `in_locked` passes through a 2-flop synchroniser; its output is `lock_s`. The FSM and all counters use only `lock_s`.
- FSM states and encodings: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3. A single shared cycle counter `cnt` is cleared on every state transition.
- **RESET_PLL:** `out_pll_rst`=1, `out_sys_rst_n`=0. When `cnt`==RST_PULSE-1, go to WAIT_LOCK.
- **WAIT_LOCK:** `out_pll_rst`=0.
  - If `lock_s`=1, go to STABILIZE.
  - Otherwise, if `cnt`==LOCK_TIMEOUT-1, set `out_timeout` and go to RESET_PLL.
  - Lock takes priority when both conditions hold on the same cycle.
- **STABILIZE:**
  - If `lock_s`=0, return to WAIT_LOCK; the timeout window restarts.
  - If `lock_s`=1 and `cnt`==STABLE_CYCLES-1, go to RUN.
- **RUN:** `out_sys_rst_n`=1. A glitch counter `gcnt` increments on each `lock_s`=0 sample and clears on each `lock_s`=1 sample.
  - When the GLITCH_CYCLES-th consecutive low sample is seen, go to RESET_PLL and increment `out_loss_cnt`.
  - `out_loss_cnt` saturates at 2^CNT_W-1.
  - Shorter low runs are filtered and cause no effect.
- All outputs are registered; `out_sys_rst_n` is 1 exactly when the registered state is RUN.
- Counter widths are `$clog2` of the largest parameter compared against. No counter wraps: each is cleared on transition before it can overflow.

## Timing
- **Reset values:** state=RESET_PLL, `cnt`=0, `gcnt`=0, `out_pll_rst`=1, `out_sys_rst_n`=0, `out_timeout`=0, `out_loss_cnt`=0, synchroniser flops=0.
- **Reset mid-operation:** `in_rst_n` low forces the reset values asynchronously from any state. After release, the sequence restarts at RESET_PLL with a full RST_PULSE.
- **PLL reset pulse:** `out_pll_rst` is high for exactly RST_PULSE cycles after reset release or after any re-entry to RESET_PLL.
- **Lock latency:** with `in_locked` settled high before edge 1 while in WAIT_LOCK, `out_sys_rst_n` rises at edge STABLE_CYCLES+3.
- **Loss latency:** with `in_locked` settled low before edge 1 while in RUN, `out_sys_rst_n` falls and `out_pll_rst` rises at edge GLITCH_CYCLES+2.
- **Timeout:** `out_timeout` rises on the same edge as the WAIT_LOCK→RESET_PLL transition.

## Configuration
- Macro `PLL_MON_LOSS_CNT_EN`.
- **Defined:** `out_loss_cnt` is implemented as described above.
- **Undefined:** the counter register is removed, `out_loss_cnt` is tied to 0, and all other behaviour is identical.

## Structure
- Package `pll_mon_pkg`:
  - `pll_mon_state_t` enum with the four encodings above.
  - Localparams for the state encodings exported on `out_state`.
- Sub-module `pll_mon_sync`: 2-flop synchroniser with asynchronous active-low reset to 0. It is reused for `in_locked` and is the only place for synchroniser timing constraints.
- Everything else (FSM, counters, output registers) lives in a single always block set in `pll_lock_monitor`.

## Test plan
All scenarios use LOCK_TIMEOUT=1000, STABLE_CYCLES=256, RST_PULSE=16, GLITCH_CYCLES=4.
- **Normal bring-up:** release reset, raise `in_locked` at cycle 30 → `out_pll_rst` high for cycles 0–15; `out_sys_rst_n` rises 259 edges after `in_locked` rises; `out_state`=3.
- **Lock timeout:** keep `in_locked`=0 → `out_timeout` rises at cycle 1016; `out_pll_rst` is high again for 16 cycles; a later lock completes bring-up and `out_timeout` stays 1.
- **Glitch filter:** in RUN, drop `in_locked` for 3 cycles → no change. Drop it for 4 cycles → `out_sys_rst_n` falls at edge 6 after the drop; `out_loss_cnt`=1.
- **Stabilize abort:** drop `in_locked` for 1 cycle at STABILIZE count 100 → returns to WAIT_LOCK; release occurs 256+ cycles after the next stable rise.
- **Saturation:** force 300 loss events → `out_loss_cnt`=255.
  - With `PLL_MON_LOSS_CNT_EN` undefined → `out_loss_cnt`=0 throughout.
- **Asynchronous reset in RUN:** pulse `in_rst_n` low mid-cycle → `out_sys_rst_n`=0 and `out_pll_rst`=1 immediately; all counters and flags clear.
